// File: rtl/flush_sequencer.sv
// Serialises IBAR / TLB-maintenance commits: drains the dcache, invalidates the
// icache, flushes TLB lookup state, then flushes the pipe and refetches op_pc+4.
module flush_sequencer #(
  parameter int DRAIN_MIN = 2,
  parameter int PC_W      = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            exc_valid,
  input  logic            ibar_valid,
  input  logic            tlbop_valid,
  input  logic [PC_W-1:0] op_pc,
  input  logic            dcache_idle,
  input  logic            icache_inv_ack,
  input  logic            tlb_flush_ack,
  output logic            flush_pipe,
  output logic            refetch_valid,
  output logic [PC_W-1:0] refetch_pc,
  output logic            icache_inv_req,
  output logic            tlb_flush_req,
  output logic            stall_commit
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    ICINV,
    TLBFL,
    DONE,
    EXC
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [3:0]      drain_cnt;
  logic            tlb_pending;
  logic [PC_W-1:0] pc_q;
  logic            drain_done;

  // Counter reads 0 in the first DRAIN cycle, so cnt+1 is the number of DRAIN cycles so far.
  assign drain_done = ({1'b0, drain_cnt} + 5'd1) >= 5'(DRAIN_MIN);

  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (exc_valid)        state_next = EXC;
        else if (ibar_valid)  state_next = DRAIN;
        else if (tlbop_valid) state_next = TLBFL;
      end
      DRAIN: if (drain_done && dcache_idle) state_next = ICINV;
      ICINV: if (icache_inv_ack) state_next = tlb_pending ? TLBFL : DONE;
      TLBFL: if (tlb_flush_ack) state_next = DONE;
      DONE:  state_next = IDLE;
      EXC:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from state_next, so each one equals a decode of the
  // current state and no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= IDLE;
      drain_cnt      <= '0;
      tlb_pending    <= 1'b0;
      pc_q           <= '0;
      flush_pipe     <= 1'b0;
      refetch_valid  <= 1'b0;
      refetch_pc     <= '0;
      icache_inv_req <= 1'b0;
      tlb_flush_req  <= 1'b0;
      stall_commit   <= 1'b0;
    end else begin
      state <= state_next;

      if (state != DRAIN)        drain_cnt <= '0;
      else if (drain_cnt != 4'hF) drain_cnt <= drain_cnt + 4'd1;

      if (state == IDLE && !exc_valid && (ibar_valid || tlbop_valid))
        pc_q <= op_pc;

      if (state == IDLE && !exc_valid && ibar_valid)
        tlb_pending <= tlbop_valid;
      else if (state == TLBFL && tlb_flush_ack)
        tlb_pending <= 1'b0;

      flush_pipe     <= (state_next == EXC) || (state_next == DONE);
      refetch_valid  <= (state_next == DONE);
      icache_inv_req <= (state_next == ICINV);
      tlb_flush_req  <= (state_next == TLBFL);
      stall_commit   <= (state_next != IDLE);

      // Wraps modulo 2^PC_W; value is held between sequences.
      if (state_next == DONE)
        refetch_pc <= pc_q + PC_W'(4);
    end
  end

endmodule

// File: tb/tb_flush_sequencer.sv
// Directed bench for flush_sequencer: a per-cycle vector table plus hand-written
// sequences for the drain wait and the full IBAR+TLB ordering.
module tb_flush_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        exc_valid, ibar_valid, tlbop_valid;
  logic [31:0] op_pc;
  logic        dcache_idle, icache_inv_ack, tlb_flush_ack;
  logic        flush_pipe, refetch_valid;
  logic [31:0] refetch_pc;
  logic        icache_inv_req, tlb_flush_req, stall_commit;

  int checks = 0;
  int errors = 0;

  flush_sequencer #(.DRAIN_MIN(2), .PC_W(32)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .exc_valid      (exc_valid),
    .ibar_valid     (ibar_valid),
    .tlbop_valid    (tlbop_valid),
    .op_pc          (op_pc),
    .dcache_idle    (dcache_idle),
    .icache_inv_ack (icache_inv_ack),
    .tlb_flush_ack  (tlb_flush_ack),
    .flush_pipe     (flush_pipe),
    .refetch_valid  (refetch_valid),
    .refetch_pc     (refetch_pc),
    .icache_inv_req (icache_inv_req),
    .tlb_flush_req  (tlb_flush_req),
    .stall_commit   (stall_commit)
  );

  always #5 clk = ~clk;

  // One row = inputs held for one cycle, outputs expected after that cycle's rising edge.
  typedef struct {
    logic        rstn, exc, ibar, tlbop;
    logic [31:0] pc;
    logic        dci, ica, tla;
    logic [4:0]  exp;     // {flush_pipe, refetch_valid, icache_inv_req, tlb_flush_req, stall_commit}
    logic        chk_pc;
    logic [31:0] rpc;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(logic r, logic e, logic i, logic t, logic [31:0] pc,
                              logic dci, logic ica, logic tla, logic [4:0] exp,
                              logic chk_pc, logic [31:0] rpc);
    vec_t v;
    v.rstn = r; v.exc = e; v.ibar = i; v.tlbop = t; v.pc = pc;
    v.dci = dci; v.ica = ica; v.tla = tla; v.exp = exp;
    v.chk_pc = chk_pc; v.rpc = rpc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [4:0] outs();
    return {flush_pipe, refetch_valid, icache_inv_req, tlb_flush_req, stall_commit};
  endfunction

  task automatic idle_inputs();
    exc_valid = 0; ibar_valid = 0; tlbop_valid = 0;
    icache_inv_ack = 0; tlb_flush_ack = 0;
  endtask

  initial begin
    int code, last, icnt, tcnt;
    int order;
    logic done, stall_ok;
    logic [31:0] done_pc;

    rstn = 0; op_pc = '0; dcache_idle = 0;
    idle_inputs();
    @(negedge clk);
    step();

    //           rstn exc ibar tlb pc            dci ica tla exp       chk rpc
    tbl[0]  = mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 5'b00000, 1, 32'h0);
    tbl[1]  = mk(1, 0, 0, 0, 32'h0,         0, 0, 0, 5'b00000, 0, 32'h0);
    tbl[2]  = mk(1, 1, 1, 0, 32'h0000_0040, 1, 0, 0, 5'b10001, 0, 32'h0);
    tbl[3]  = mk(1, 0, 0, 0, 32'h0,         1, 0, 0, 5'b00000, 0, 32'h0);
    tbl[4]  = mk(1, 0, 0, 0, 32'h0,         1, 0, 0, 5'b00000, 0, 32'h0);
    tbl[5]  = mk(1, 0, 0, 1, 32'h1C00_0100, 0, 0, 1, 5'b00011, 0, 32'h0);
    tbl[6]  = mk(1, 0, 0, 0, 32'h0,         0, 0, 1, 5'b11001, 1, 32'h1C00_0104);
    tbl[7]  = mk(1, 0, 0, 0, 32'h0,         0, 0, 1, 5'b00000, 0, 32'h0);
    tbl[8]  = mk(1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 5'b00011, 0, 32'h0);
    tbl[9]  = mk(1, 1, 1, 0, 32'h0,         0, 0, 0, 5'b00011, 0, 32'h0);
    tbl[10] = mk(1, 0, 0, 0, 32'h0,         0, 0, 1, 5'b11001, 1, 32'h0000_0000);
    tbl[11] = mk(1, 0, 0, 0, 32'h0,         0, 0, 0, 5'b00000, 0, 32'h0);
    tbl[12] = mk(1, 0, 0, 0, 32'h0,         1, 1, 1, 5'b00000, 0, 32'h0);
    tbl[13] = mk(1, 0, 1, 0, 32'h0000_1000, 1, 0, 0, 5'b00001, 0, 32'h0);
    tbl[14] = mk(1, 0, 0, 0, 32'h0,         1, 0, 0, 5'b00001, 0, 32'h0);
    tbl[15] = mk(1, 0, 0, 0, 32'h0,         1, 0, 0, 5'b00101, 0, 32'h0);
    tbl[16] = mk(0, 0, 0, 0, 32'h0,         1, 0, 0, 5'b00000, 1, 32'h0);
    tbl[17] = mk(1, 0, 0, 0, 32'h0,         1, 1, 0, 5'b00000, 0, 32'h0);
    tbl[18] = mk(1, 0, 0, 0, 32'h0,         1, 1, 0, 5'b00000, 0, 32'h0);

    foreach (tbl[i]) begin
      rstn = tbl[i].rstn; exc_valid = tbl[i].exc; ibar_valid = tbl[i].ibar;
      tlbop_valid = tbl[i].tlbop; op_pc = tbl[i].pc; dcache_idle = tbl[i].dci;
      icache_inv_ack = tbl[i].ica; tlb_flush_ack = tbl[i].tla;
      step();
      check($sformatf("vec%0d outs", i), 32'(outs()), 32'(tbl[i].exp));
      if (tbl[i].chk_pc) check($sformatf("vec%0d refetch_pc", i), refetch_pc, tbl[i].rpc);
    end

    // Drain wait: dcache busy for four DRAIN cycles, idle on the fifth.
    idle_inputs(); rstn = 1;
    ibar_valid = 1; op_pc = 32'h0000_3000; dcache_idle = 0;
    step();
    ibar_valid = 0;
    check("drain entry", 32'(outs()), 32'(5'b00001));
    for (int k = 1; k <= 5; k++) begin
      dcache_idle = (k == 5);
      step();
      check($sformatf("drain k%0d", k), 32'(outs()), (k == 5) ? 32'(5'b00101) : 32'(5'b00001));
    end
    dcache_idle = 0;
    step();
    check("icinv hold1", 32'(outs()), 32'(5'b00101));
    step();
    check("icinv hold2", 32'(outs()), 32'(5'b00101));
    icache_inv_ack = 1;
    step();
    icache_inv_ack = 0;
    check("drain done outs", 32'(outs()), 32'(5'b11001));
    check("drain done pc", refetch_pc, 32'h0000_3004);
    step();
    check("drain back idle", 32'(outs()), 32'(5'b00000));

    // Full IBAR+TLB sequence, each ack given in the third cycle of its request.
    ibar_valid = 1; tlbop_valid = 1; op_pc = 32'h0000_2000; dcache_idle = 1;
    step();
    ibar_valid = 0; tlbop_valid = 0;
    last = 0; order = 0; icnt = 0; tcnt = 0; done = 0; stall_ok = 1; done_pc = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (flush_pipe && refetch_valid)  code = 4;
      else if (tlb_flush_req)           code = 3;
      else if (icache_inv_req)          code = 2;
      else if (stall_commit)            code = 1;
      else                              code = 0;
      if (!stall_commit) stall_ok = 0;
      if (code != last) order = (order << 4) | code;
      last = code;
      if (code == 2) icnt++;
      if (code == 3) tcnt++;
      if (code == 4) begin done = 1; done_pc = refetch_pc; end
      icache_inv_ack = (code == 2) && (icnt == 3);
      tlb_flush_ack  = (code == 3) && (tcnt == 3);
      if (!done) step();
    end
    idle_inputs();
    check("seq done reached", 32'(done), 32'd1);
    check("seq order", 32'(order), 32'h0000_1234);
    check("seq stall", 32'(stall_ok), 32'd1);
    check("seq icinv cycles", 32'(icnt), 32'd3);
    check("seq tlbfl cycles", 32'(tcnt), 32'd3);
    check("seq refetch_pc", done_pc, 32'h0000_2004);
    step();
    check("seq back idle", 32'(outs()), 32'(5'b00000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
